// File: rtl/de270_pio_pkg.sv
// Shared constants and helpers for the DE270 PIO slaves: register word
// addresses and the edge-selection encoding used by the key input PIO.
package de270_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Per-bit edge event between the current and previous debounced level.
    function automatic logic [31:0] edge_event(input edge_type_e kind,
                                               input logic [31:0] cur,
                                               input logic [31:0] prev);
        case (kind)
            EDGE_RISE: return cur & ~prev;
            EDGE_FALL: return ~cur & prev;
            default:   return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/de270_key_debounce.sv
// One key bit: two-flop synchroniser followed by a hold-time debouncer.
// The level is accepted once the synchronised input differs for DEBOUNCE_CYCLES cycles.
module de270_key_debounce #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_i,
    output logic sync_o,
    output logic stable_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= IDLE_LEVEL;
            sync2_q  <= IDLE_LEVEL;
            stable_q <= IDLE_LEVEL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Counter restarts whenever the input agrees with the accepted level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign sync_o   = sync2_q;
    assign stable_o = stable_q;

endmodule

// File: rtl/de270_pio_key_in.sv
// Avalon-MM key input PIO: debounced DATA, interrupt mask and a sticky
// W1C edge-capture register driving a level interrupt.
module de270_pio_key_in
    import de270_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int IDLE_LEVEL      = 1,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic             IDLE_BIT = (IDLE_LEVEL != 0);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_BIT}};
    localparam edge_type_e       EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);

    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] armed_q, armed_d;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] w1c;
    logic [1:0]       settle_q, settle_d;
    logic             settled;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        de270_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL     (IDLE_BIT)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .key_i   (in_port[i]),
            .sync_o  (sync2[i]),
            .stable_o(stable[i])
        );
    end

    assign wr_en        = chipselect && !write_n;
    assign settled      = (settle_q == 2'd2);
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_prev_q <= IDLE_VEC;
            mask_q        <= '0;
            cap_q         <= '0;
            armed_q       <= '0;
            settle_q      <= '0;
        end else begin
            stable_prev_q <= stable;
            mask_q        <= mask_d;
            cap_q         <= cap_d;
            armed_q       <= armed_d;
            settle_q      <= settle_d;
        end
    end

    // A bit only reports edges once it has been seen released after reset
    // (synchroniser flushed), so a key held through reset raises no event.
    always_comb begin
        settle_d = settle_q;
        if (!settled) begin
            settle_d = settle_q + 2'd1;
        end
        armed_d  = armed_q | ({WIDTH{settled}} & ~(sync2 ^ IDLE_VEC) & ~(stable ^ IDLE_VEC));
        edge_evt = WIDTH'(edge_event(EDGE_SEL, 32'(stable), 32'(stable_prev_q))) & armed_q;

        mask_d = mask_q;
        w1c    = '0;
        if (wr_en && address == PIO_ADDR_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == PIO_ADDR_EDGE) begin
            w1c = writedata[WIDTH-1:0];
        end
        // A new event wins over a clear of the same bit.
        cap_d = (cap_q & ~w1c) | edge_evt;
    end

    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA: readdata[WIDTH-1:0] = stable;
            PIO_ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
            PIO_ADDR_EDGE: readdata[WIDTH-1:0] = cap_q;
            default:       readdata = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_de270_pio_key_in.sv
// Bench for de270_pio_key_in: directed register/debounce scenarios plus
// randomized key and bus traffic, checked every cycle against a level-history model.
module tb_de270_pio_key_in;

    localparam int W = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int n_vec;
    int n_err;

    // model state
    logic [W-1:0] m_sync1, m_sync2, m_stable, m_prev, m_mask, m_cap, m_armed;
    logic [W-1:0] m_win [D];
    int           m_age;

    de270_pio_key_in #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .IDLE_LEVEL(1), .EDGE_TYPE(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: a key level is accepted once the last D synchronised
    // samples all disagree with the current accepted level
    task automatic model_reset();
        m_sync1  = 4'hF;
        m_sync2  = 4'hF;
        m_stable = 4'hF;
        m_prev   = 4'hF;
        m_mask   = '0;
        m_cap    = '0;
        m_armed  = '0;
        m_age    = 0;
        for (int j = 0; j < D; j++) m_win[j] = 4'hF;
    endtask

    task automatic model_step();
        logic [W-1:0] evt, clr, nxt;
        logic         all_diff;
        evt = ~m_stable & m_prev & m_armed;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        m_cap = (m_cap & ~clr) | evt;
        if (m_age >= 2) m_armed = m_armed | (m_sync2 & m_stable);
        for (int j = D - 1; j > 0; j--) m_win[j] = m_win[j-1];
        m_win[0] = m_sync2;
        nxt = m_stable;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) if (m_win[j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nxt[b] = ~m_stable[b];
        end
        m_prev   = m_stable;
        m_stable = nxt;
        m_sync2  = m_sync1;
        m_sync1  = in_port;
        if (m_age < 2) m_age++;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'b0, m_stable};
            2'd2:    return {28'b0, m_mask};
            2'd3:    return {28'b0, m_cap};
            default: return 32'b0;
        endcase
    endfunction

    always @(posedge clk) if (reset_n) model_step();

    // scoreboard: compare every cycle, away from the active edge
    always @(negedge clk) begin
        #1;
        check("readdata", readdata, model_read(address));
        check("irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    end

    // driver tasks
    task automatic step_raw(input logic [W-1:0] in_v, input logic [1:0] a,
                            input logic cs, input logic wn, input logic [31:0] wd);
        @(negedge clk);
        in_port    = in_v;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        #2;
    endtask

    task automatic step(input logic [W-1:0] in_v, input logic [1:0] a,
                        input logic wr, input logic [31:0] wd);
        step_raw(in_v, a, 1'b1, ~wr, wd);
    endtask

    task automatic hold(input logic [W-1:0] in_v, input logic [1:0] a, input int n);
        for (int i = 0; i < n; i++) step(in_v, a, 1'b0, 32'h0);
    endtask

    task automatic assert_reset(input logic [W-1:0] in_v, input logic [1:0] a);
        @(negedge clk);
        reset_n    = 1'b0;
        model_reset();
        in_port    = in_v;
        address    = a;
        chipselect = 1'b0;
        write_n    = 1'b1;
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #2;
    endtask

    initial begin
        logic seen;
        logic [W-1:0] r_in;
        n_vec = 0;
        n_err = 0;
        model_reset();
        reset_n = 1'b0; in_port = 4'hF; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;

        // reset state
        hold(4'hF, 2'd0, 3);
        release_reset();
        step(4'hF, 2'd0, 1'b0, 0); check("rst_data", readdata, 32'hF);
        step(4'hF, 2'd1, 1'b0, 0); check("rst_rsvd", readdata, 32'h0);
        step(4'hF, 2'd2, 1'b0, 0); check("rst_mask", readdata, 32'h0);
        step(4'hF, 2'd3, 1'b0, 0); check("rst_cap", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        step(4'hF, 2'd1, 1'b1, 32'hFFFF_FFFF);
        step(4'hF, 2'd0, 1'b1, 32'h0);
        step(4'hF, 2'd1, 1'b0, 0); check("rsvd_wr_ignored", readdata, 32'h0);
        step(4'hF, 2'd0, 1'b0, 0); check("data_wr_ignored", readdata, 32'hF);

        // press key 0, sampled at edge k
        step(4'hE, 2'd0, 1'b0, 0);
        for (int i = 1; i <= 6; i++) begin
            step(4'hE, 2'd0, 1'b0, 0);
            if (i == 5) check("press_data_k4", readdata, 32'hF);
            if (i == 6) check("press_data_k5", readdata, 32'hE);
        end
        step(4'hE, 2'd3, 1'b0, 0); check("press_cap_k6", readdata, 32'h1);
        check("press_irq_masked", {31'b0, irq}, 32'h0);

        // mask, interrupt and W1C
        step(4'hE, 2'd3, 1'b1, 32'h1);
        hold(4'hF, 2'd0, 10);
        step(4'hF, 2'd3, 1'b0, 0); check("release_no_cap", readdata, 32'h0);
        step(4'hF, 2'd2, 1'b1, 32'h1);
        step(4'hF, 2'd2, 1'b0, 0); check("mask_rb", readdata, 32'h1);
        hold(4'hE, 2'd0, 8);
        check("irq_set", {31'b0, irq}, 32'h1);
        step(4'hE, 2'd3, 1'b1, 32'h1);
        check("irq_before_clr", {31'b0, irq}, 32'h1);
        step(4'hE, 2'd0, 1'b0, 0);
        check("irq_after_clr", {31'b0, irq}, 32'h0);
        check("data_after_clr", readdata, 32'hE);

        // glitch filtering on key 1
        hold(4'hF, 2'd0, 10);
        step(4'hF, 2'd3, 1'b1, 32'hF);
        hold(4'hD, 2'd0, 3);
        for (int i = 0; i < 12; i++) begin
            step(4'hF, 2'd0, 1'b0, 0); check("glitch3_data", readdata, 32'hF);
        end
        step(4'hF, 2'd3, 1'b0, 0); check("glitch3_cap", readdata, 32'h0);
        hold(4'hD, 2'd0, 4);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(4'hF, 2'd0, 1'b0, 0);
            if (readdata == 32'hD) seen = 1'b1;
        end
        check("pulse4_seen_D", {31'b0, seen}, 32'h1);
        check("pulse4_data_back", readdata, 32'hF);
        step(4'hF, 2'd3, 1'b0, 0); check("pulse4_cap", readdata, 32'h2);

        // edge event on bit 2 coincides with W1C of bit 2
        step(4'hF, 2'd3, 1'b1, 32'h2);
        step(4'hB, 2'd0, 1'b0, 0);
        hold(4'hB, 2'd0, 5);
        step(4'hB, 2'd3, 1'b1, 32'h4);
        step(4'hB, 2'd3, 1'b0, 0); check("set_wins_over_clr", readdata, 32'h4);
        step(4'hB, 2'd3, 1'b1, 32'h4);
        step(4'hB, 2'd3, 1'b0, 0); check("clr_alone", readdata, 32'h0);

        // reset mid-debounce with key 0 held through reset
        hold(4'hF, 2'd0, 10);
        step(4'hE, 2'd0, 1'b0, 0);
        hold(4'hE, 2'd0, 3);
        assert_reset(4'hE, 2'd2);
        check("midrst_mask", readdata, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        step_raw(4'hE, 2'd0, 1'b0, 1'b1, 0); check("midrst_data", readdata, 32'hF);
        step_raw(4'hE, 2'd3, 1'b0, 1'b1, 0); check("midrst_cap", readdata, 32'h0);
        release_reset();
        hold(4'hE, 2'd0, 12);
        check("held_data", readdata, 32'hE);
        step(4'hE, 2'd3, 1'b0, 0); check("held_no_cap", readdata, 32'h0);
        hold(4'hF, 2'd0, 8);
        hold(4'hE, 2'd0, 8);
        step(4'hE, 2'd3, 1'b0, 0); check("repress_cap", readdata, 32'h1);

        // randomized traffic
        r_in = 4'hF;
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 5) == 0) r_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                assert_reset(r_in, 2'($urandom_range(0, 3)));
                step_raw(r_in, 2'($urandom_range(0, 3)), 1'b0, 1'b1, 0);
                release_reset();
            end else begin
                step_raw(r_in, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 2) != 0), $urandom);
            end
        end
        step(r_in, 2'd0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/de270_pio_key_in.md
# de270_pio_key_in

Memory-mapped input PIO with per-bit synchroniser, debounce, edge capture and maskable interrupt. Reads active-low push-buttons into the DE270 system as an Avalon-MM slave on the same bus as the LED output PIO. The data register reads back the debounced input level. Qualifying edges latch into a sticky capture register that drives a level interrupt to the processor.

## Interface
- WIDTH, 4: number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive clk cycles an input must hold a new level before it is accepted (≥1; 1 ms at 50 MHz).
- IDLE_LEVEL, 1: level of every bit when released; reset value of the synchroniser and debounce stages.
- EDGE_TYPE, 1: edge that sets capture. 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address; unused bits 0.
- in_port  in  WIDTH  asynchronous raw key inputs.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map (word addresses):
  - 0 DATA: RO, debounced level `stable[WIDTH-1:0]`.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK: RW, WIDTH bits.
  - 3 EDGE_CAP: read returns capture bits. Write is write-1-to-clear per bit.
- Write occurs when chipselect && !write_n. Writes to address 0 and address 1 are ignored.
- Per bit pipeline:
  - Two-flop synchroniser: sync1, then sync2.
  - Debounce counter cnt, $clog2(DEBOUNCE_CYCLES+1) bits:
    - If sync2 == stable: cnt <= 0.
    - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
    - Else: cnt <= cnt+1.
  - stable_d <= stable every cycle.
  - Edge event per bit:
    - Rising: stable & ~stable_d.
    - Falling: ~stable & stable_d.
    - Any: stable ^ stable_d.
- Capture register: each bit sets on its edge event and holds until cleared.
- Simultaneous edge event and W1C on the same bit in one cycle: set wins and the bit stays 1.
- irq = |(edge_cap & irq_mask), combinational from registers.
- Glitches shorter than DEBOUNCE_CYCLES cycles are never visible at DATA and never set capture.
- Counter wrap: cnt is bounded by DEBOUNCE_CYCLES-1 and never wraps.

## Timing
- Reset values:
  - sync1, sync2, stable and stable_d are {WIDTH{IDLE_LEVEL}}.
  - cnt = 0, irq_mask = 0, edge_cap = 0.
  - Outputs: irq = 0; readdata at address 0 reads {WIDTH{IDLE_LEVEL}} zero-extended.
- Latency: for an in_port change sampled at clk edge k that then holds clean, sync2 shows the new value after edge k+1. stable updates at edge k+1+DEBOUNCE_CYCLES. edge_cap and irq assert at edge k+2+DEBOUNCE_CYCLES.
- Reads are zero-wait: readdata is valid in the same cycle as address.
- Register writes take effect at the next clk edge. irq deasserts the cycle after a clearing write or a mask clear, unless a new edge sets the bit in that same cycle.
- Reset asserted mid-debounce or mid-capture: all state returns to reset values immediately. No edge is reported for an input held at a non-idle level through reset until the input is released and pressed again.

## Structure
- Package de270_pio_pkg:
  - Address constants PIO_ADDR_DATA=0, PIO_ADDR_MASK=2, PIO_ADDR_EDGE=3.
  - EDGE_TYPE encodings EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module de270_key_debounce: one bit of synchroniser, counter and stable register, with parameters DEBOUNCE_CYCLES and IDLE_LEVEL. It is instantiated WIDTH times in a generate loop. The top level holds the edge detect, the registers and the read mux.

## Test plan
Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=4, IDLE_LEVEL=1, EDGE_TYPE=1.
- Reset → read addr 0 = 0x0000000F, addr 2 = 0, addr 3 = 0, addr 1 = 0; irq = 0.
- Drive in_port[0] = 0 at edge k and hold → DATA reads 0xE from edge k+5; EDGE_CAP bit 0 = 1 at edge k+6; irq stays 0 while mask = 0.
- Write mask = 0x1, then press key 0 → irq = 1. Write addr 3 = 0x1 → irq = 0 next cycle; DATA still 0xE.
- Pulse in_port[1] low for 3 cycles → DATA stays 0xF, EDGE_CAP = 0, irq = 0. Pulse it low for 4 cycles → DATA shows 0xD, then 0xF once released, and EDGE_CAP bit 1 = 1.
- Time a falling edge event on bit 2 to the same cycle as a write of addr 3 = 0x4 → EDGE_CAP bit 2 stays 1.
- Assert reset_n low mid-debounce (cnt = 2) → all registers return to reset values. Hold in_port = 0xE through reset → after release, capture bit 0 stays 0 until the key goes high and low again.
